// File: rtl/approx_eval_pkg.sv
// Shared state encoding, sizing defaults and abs-difference helper for the adder error monitor.
package approx_eval_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int DRAIN_CYCLES = 2;
    localparam int DEF_WIDTH    = 16;
    localparam int DEF_CNT_W    = 16;
    localparam int ABS_MAX_W    = 64;

    // Callers zero-extend into the wide form and truncate the result back.
    function automatic logic [ABS_MAX_W-1:0] abs_diff(input logic [ABS_MAX_W-1:0] x,
                                                      input logic [ABS_MAX_W-1:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/approx_err_datapath.sv
// Exact-sum / abs-error pipeline plus statistic accumulators (sum_sq_err with APPROX_ERR_MSE_EN).
// Latency: 2 cycles from accepted triple to updated statistics.
// Backpressure: none; every valid beat is absorbed, one per cycle.
module approx_err_datapath
    import approx_eval_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int ACC_W = WIDTH + 1 + CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH:0]   approx,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ACC_W-1:0] sum_abs_err,
    output logic [WIDTH:0]   max_abs_err
`ifdef APPROX_ERR_MSE_EN
    ,
    output logic [2*(WIDTH+1)+CNT_W-1:0] sum_sq_err
`endif
);

    logic           s1_valid;
    logic [WIDTH:0] s1_exact;
    logic [WIDTH:0] s1_approx;
    logic [WIDTH:0] d;

    assign d = (WIDTH+1)'(abs_diff(ABS_MAX_W'(s1_exact), ABS_MAX_W'(s1_approx)));

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_exact  <= '0;
            s1_approx <= '0;
        end else begin
            s1_valid <= valid;
            if (valid) begin
                s1_exact  <= {1'b0, a} + {1'b0, b};
                s1_approx <= approx;
            end
        end
    end

    // clear only arrives in IDLE/DONE, when the pipeline is already empty.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sample_cnt  <= '0;
            err_cnt     <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
        end else if (s1_valid) begin
            sample_cnt  <= sample_cnt + CNT_W'(1);
            err_cnt     <= err_cnt + CNT_W'(d != '0);
            sum_abs_err <= sum_abs_err + ACC_W'(d);
            if (d > max_abs_err)
                max_abs_err <= d;
        end
    end

`ifdef APPROX_ERR_MSE_EN
    localparam int SQ_W = 2*(WIDTH+1) + CNT_W;

    always_ff @(posedge clk) begin
        if (rst || clear)
            sum_sq_err <= '0;
        else if (s1_valid)
            sum_sq_err <= sum_sq_err + SQ_W'(d) * SQ_W'(d);
    end
`endif

endmodule

// File: rtl/approx_err_monitor.sv
// Error-statistic collector for an approximate adder; APPROX_ERR_MSE_EN adds sum_sq_err.
// Latency: stats settle 2 cycles after the last transfer; done one cycle after that.
// Backpressure: in_ready high only in RUN; beats offered while low are dropped.
module approx_err_monitor
    import approx_eval_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int ACC_W = WIDTH + 1 + CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH:0]   in_approx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ACC_W-1:0] sum_abs_err,
    output logic [WIDTH:0]   max_abs_err
`ifdef APPROX_ERR_MSE_EN
    ,
    output logic [2*(WIDTH+1)+CNT_W-1:0] sum_sq_err
`endif
);

    state_t           state;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] acc_cnt;
    logic [1:0]       drain_cnt;
    logic             xfer;
    logic             clear;

    assign xfer  = in_valid & in_ready;
    assign clear = start & ((state == IDLE) | (state == DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            target    <= '0;
            acc_cnt   <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        acc_cnt <= '0;
                        if (num_samples != '0) begin
                            target   <= num_samples;
                            state    <= RUN;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                            done     <= 1'b0;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (xfer) begin
                        acc_cnt <= acc_cnt + CNT_W'(1);
                        if (acc_cnt + CNT_W'(1) == target) begin
                            state     <= DRAIN;
                            in_ready  <= 1'b0;
                            drain_cnt <= 2'(DRAIN_CYCLES - 1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    approx_err_datapath #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W),
        .ACC_W(ACC_W)
    ) u_datapath (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .valid      (xfer),
        .a          (in_a),
        .b          (in_b),
        .approx     (in_approx),
        .sample_cnt (sample_cnt),
        .err_cnt    (err_cnt),
        .sum_abs_err(sum_abs_err),
        .max_abs_err(max_abs_err)
`ifdef APPROX_ERR_MSE_EN
        ,
        .sum_sq_err (sum_sq_err)
`endif
    );

endmodule

// File: tb/tb_approx_err_monitor.sv
// Randomised scoreboard bench for approx_err_monitor; reference stats computed from accepted triples.
module tb_approx_err_monitor;
    localparam int WIDTH = 16;
    localparam int CNT_W = 16;
    localparam int ACC_W = WIDTH + 1 + CNT_W;
    localparam int SQ_W  = 2*(WIDTH+1) + CNT_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_samples;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH:0]   in_approx;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [ACC_W-1:0] sum_abs_err;
    logic [WIDTH:0]   max_abs_err;
`ifdef APPROX_ERR_MSE_EN
    logic [SQ_W-1:0]  sum_sq_err;
`endif

    always #5 clk = ~clk;

    approx_err_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_approx(in_approx), .busy(busy), .done(done), .sample_cnt(sample_cnt),
        .err_cnt(err_cnt), .sum_abs_err(sum_abs_err), .max_abs_err(max_abs_err)
`ifdef APPROX_ERR_MSE_EN
        , .sum_sq_err(sum_sq_err)
`endif
    );

    typedef struct {
        longint sc;
        longint ec;
        longint sae;
        longint mae;
        longint sse;
    } exp_t;

    exp_t exp_q[$];
    int   st_a[$];
    int   st_b[$];
    int   st_x[$];
    bit   st_v[$];
    bit   st_s[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit start_q = 1'b0;
    bit prev_done = 1'b0;
    int run_xfers = 0;
    int first_edge = 0;
    int last_edge = 0;
    int done_edge = 0;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic clear_steps();
        st_a.delete(); st_b.delete(); st_x.delete(); st_v.delete(); st_s.delete();
    endtask

    task automatic add_step(input bit v, input int a, input int b, input int x, input bit s);
        st_v.push_back(v); st_a.push_back(a); st_b.push_back(b); st_x.push_back(x); st_s.push_back(s);
    endtask

    task automatic drive_start(input int n);
        run_xfers   = 0;
        start       = 1'b1;
        num_samples = CNT_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive_steps();
        for (int i = 0; i < st_v.size(); i++) begin
            in_valid  = st_v[i];
            in_a      = WIDTH'(st_a[i]);
            in_b      = WIDTH'(st_b[i]);
            in_approx = (WIDTH+1)'(st_x[i]);
            start     = st_s[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    // Reference: the first n valid beats after start are accepted; stats follow directly.
    task automatic do_run(input int n);
        exp_t   e;
        int     acc;
        longint d;
        e   = '{default: 0};
        acc = 0;
        for (int i = 0; i < st_v.size(); i++) begin
            if (st_v[i] && acc < n) begin
                d = longint'(st_a[i]) + longint'(st_b[i]) - longint'(st_x[i]);
                if (d < 0) d = -d;
                e.sc++;
                if (d != 0) e.ec++;
                e.sae += d;
                if (d > e.mae) e.mae = d;
                e.sse += d * d;
                acc++;
            end
        end
        exp_q.push_back(e);
        drive_start(n);
        drive_steps();
    endtask

    task automatic wait_done(input string name, input int n);
        int k;
        k = 0;
        while (!done && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got done=0 expected done=1", name);
        end
        chk({name, "_xfers"}, run_xfers, n);
        @(posedge clk); #1;
    endtask

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        start_q <= start;
    end

    always @(negedge clk) begin
        exp_t e;
        if (in_valid && in_ready) begin
            if (run_xfers == 0) first_edge = cyc + 1;
            last_edge = cyc + 1;
            run_xfers++;
        end
        if (!rst && done && (!prev_done || start_q)) begin
            done_edge = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                e = exp_q.pop_front();
                chk("sample_cnt", longint'(sample_cnt), e.sc);
                chk("err_cnt", longint'(err_cnt), e.ec);
                chk("sum_abs_err", longint'(sum_abs_err), e.sae);
                chk("max_abs_err", longint'(max_abs_err), e.mae);
                chk("busy_in_done", longint'(busy), 0);
`ifdef APPROX_ERR_MSE_EN
                chk("sum_sq_err", longint'(sum_sq_err), e.sse);
`endif
            end
        end
        prev_done = done;
    end

    function automatic int rand_approx(input int exact);
        int x;
        case ($urandom_range(0, 3))
            0: x = exact;
            1: x = exact ^ (1 << $urandom_range(0, WIDTH));
            2: x = int'($urandom_range(0, (1 << (WIDTH+1)) - 1));
            default: x = (exact >= 3) ? exact - int'($urandom_range(0, 3)) : exact;
        endcase
        return x;
    endfunction

    task automatic add_rand_valid(input bit s);
        int a;
        int b;
        a = int'($urandom_range(0, (1 << WIDTH) - 1));
        b = int'($urandom_range(0, (1 << WIDTH) - 1));
        add_step(1'b1, a, b, rand_approx(a + b), s);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_samples = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_approx = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_in_ready", longint'(in_ready), 0);
        chk("rst_sample_cnt", longint'(sample_cnt), 0);
        @(posedge clk); #1;

        // Reset in the middle of a run discards everything.
        clear_steps();
        add_step(1, 3, 5, 7, 0); add_step(1, 6, 6, 8, 0); add_step(1, 1, 1, 2, 0);
        drive_start(8);
        drive_steps();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", longint'(busy), 0);
        chk("midrst_done", longint'(done), 0);
        chk("midrst_in_ready", longint'(in_ready), 0);
        chk("midrst_sample_cnt", longint'(sample_cnt), 0);
        chk("midrst_err_cnt", longint'(err_cnt), 0);
        chk("midrst_sum_abs_err", longint'(sum_abs_err), 0);
        chk("midrst_max_abs_err", longint'(max_abs_err), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("midrst_flushed", longint'(sample_cnt), 0);
        @(posedge clk); #1;

        // Zero-sample run from IDLE.
        clear_steps();
        do_run(0);
        @(negedge clk);
        chk("zero_done_next_cycle", longint'(done), 1);
        wait_done("zero_idle", 0);

        clear_steps();
        add_step(1, 3, 5, 8, 0); add_step(1, 65535, 1, 65536, 0);
        add_step(1, 0, 0, 0, 0); add_step(1, 100, 200, 300, 0);
        do_run(4);
        wait_done("exact", 4);

        clear_steps();
        add_step(1, 3, 5, 7, 0); add_step(1, 6, 6, 8, 0); add_step(1, 1, 1, 2, 0);
        do_run(3);
        wait_done("approx", 3);

        clear_steps();
        add_step(1, 10, 10, 4, 0);
        do_run(1);
        wait_done("rerun", 1);

        // Zero-sample restart from DONE must still clear the previous statistics.
        clear_steps();
        do_run(0);
        @(negedge clk);
        chk("zero_done_hold", longint'(done), 1);
        wait_done("zero_from_done", 0);

        clear_steps();
        for (int i = 0; i < 16; i++) add_rand_valid(0);
        do_run(16);
        wait_done("thru", 16);
        chk("thru_consecutive", last_edge - first_edge, 15);
        chk("thru_done_latency", done_edge - last_edge, 2);

        clear_steps();
        for (int i = 0; i < 6; i++) begin
            add_rand_valid(0);
            add_step(0, 7, 7, 99, 0);
        end
        do_run(6);
        wait_done("toggle", 6);

        clear_steps();
        for (int i = 0; i < 5; i++) add_rand_valid(0);
        do_run(2);
        wait_done("extra", 2);
        chk("extra_in_ready", longint'(in_ready), 0);

        clear_steps();
        add_rand_valid(0); add_rand_valid(1); add_rand_valid(0);
        add_rand_valid(1); add_rand_valid(0);
        do_run(5);
        wait_done("start_in_run", 5);

        for (int r = 0; r < 6; r++) begin
            int n;
            int acc;
            n = int'($urandom_range(1, 12));
            acc = 0;
            clear_steps();
            while (acc < n) begin
                if ($urandom_range(0, 3) != 0) begin
                    add_rand_valid(bit'($urandom_range(0, 7) == 0));
                    acc++;
                end else begin
                    add_step(0, int'($urandom_range(0, 65535)), 1, 3, 0);
                end
            end
            add_rand_valid(0);
            add_rand_valid(0);
            do_run(n);
            wait_done("random", n);
        end

        repeat (4) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/approx_err_monitor.md
Name: approx_err_monitor

Overview:
Sequential error-metric collector that sits on the output side of an approximate ripple-carry adder under evaluation. It accepts the adder's operand pairs together with the sum the adder produced, and computes the exact sum internally. It then accumulates error statistics over a programmed number of samples: total absolute error (used for MAE), maximum absolute error and the count of erroneous samples. Used in simulation benches and emulation builds to characterise the delay/MAE trade-off of each adder variant.

Parameters:
WIDTH, 16, operand width; both the exact and the approximate sums are WIDTH+1 bits.
CNT_W, 16, width of the sample counter and of num_samples.
ACC_W, WIDTH+1+CNT_W, width of the absolute-error accumulator. It is sized so that overflow is impossible.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse that begins a measurement run
num_samples  in  CNT_W  samples per run; sampled on start
in_valid  in  1  operand/result triple valid
in_ready  out  1  monitor can accept a triple
in_a  in  WIDTH  operand 1 (adder IN1)
in_b  in  WIDTH  operand 2 (adder IN2)
in_approx  in  WIDTH+1  sum produced by the approximate adder
busy  out  1  high in RUN and DRAIN
done  out  1  high in DONE; results are valid and stable
sample_cnt  out  CNT_W  samples accumulated
err_cnt  out  CNT_W  samples whose approximate sum differs from the exact sum
sum_abs_err  out  ACC_W  sum of |exact - approx|
max_abs_err  out  WIDTH+1  largest |exact - approx| seen

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state goes to IDLE. in_ready, busy and done go to 0. All counters and accumulators clear to 0. Reset wins over every other input, including in mid-run; any in-flight pipeline data is discarded.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 with num_samples!=0 latches num_samples, clears all statistics and goes to RUN.
  - start=1 with num_samples==0 goes directly to DONE with all statistics 0.
- RUN:
  - in_ready=1.
  - A transfer occurs on in_valid & in_ready. The accepted count increments.
  - When the accepted count reaches the latched target, in_ready drops the next cycle and the FSM goes to DRAIN.
  - in_valid while in_ready=0 is ignored; there is no back-pressure buffering.
- Pipeline, 2 stages, fixed latency:
  - Stage 1 registers exact = in_a + in_b (WIDTH+1 bits, zero-extended) and in_approx.
  - Stage 2 computes d = |exact - approx| as an unsigned WIDTH+1-bit value, then updates the statistics in the same cycle:
    - sum_abs_err += d;
    - max_abs_err = max(max_abs_err, d);
    - err_cnt increments when d != 0;
    - sample_cnt increments.
  - Statistics reflect a transfer 2 cycles after it is accepted.
- DRAIN: stays exactly 2 cycles until the pipeline is empty, then goes to DONE.
- DONE:
  - done=1 and busy=0; outputs are held.
  - start=1 clears the statistics and re-enters RUN, or DONE again if num_samples==0.
- start asserted in RUN or DRAIN is ignored.
- Counters never wrap, because sample_cnt never exceeds num_samples (at most 2^CNT_W-1).
- Back-to-back transfers at one per cycle must be sustained.

Optional Feature:
Macro APPROX_ERR_MSE_EN.
- Defined: adds output sum_sq_err, width 2*(WIDTH+1)+CNT_W, which accumulates d*d in stage 2 in parallel with the other updates. It is cleared on rst and on start, and held in DONE.
- Undefined: the port and the multiplier are absent; all other behaviour is identical.

Decomposition:
- Shared package approx_eval_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - localparams for DRAIN_CYCLES=2 and the default widths;
  - an abs-difference function.
- One sub-module, approx_err_datapath: the 2-stage exact-sum and abs-diff pipeline plus the accumulators. It takes a valid bit and a clear strobe from the FSM in approx_err_monitor.

Test Plan:
- Reset mid-run: start with num_samples=8, feed 3 triples, assert rst → next cycle busy=0, done=0, all stats 0, in_ready=0.
- Exact adder: start with num_samples=4; feed (3,5,8), (65535,1,65536), (0,0,0), (100,200,300) → done with sample_cnt=4, err_cnt=0, sum_abs_err=0, max_abs_err=0.
- Approximate errors: num_samples=3; feed (3,5,7), (6,6,8), (1,1,2) → err_cnt=2, sum_abs_err=5, max_abs_err=4; with APPROX_ERR_MSE_EN, sum_sq_err=17.
- Throughput and latency: in_valid held high for num_samples=16 → 16 transfers in 16 consecutive cycles; done rises exactly 2 cycles after the last transfer plus the DRAIN-to-DONE edge, with no stalls.
- Stall and boundary cases:
  - num_samples=0 → done=1 one cycle after start;
  - in_valid toggling 1/0 → only handshaked triples counted;
  - extra in_valid after the count is reached → ignored and in_ready=0;
  - start during RUN → ignored.
- Rerun: after DONE, start with num_samples=1 and feed (10,10,4) → stats cleared and end with sample_cnt=1, err_cnt=1, sum_abs_err=16, max_abs_err=16.
